data_memory_arbiter: RTL

Two-port round-robin arbiter and controller for the single-port, byte-enabled data memory. Requester 0 is the core load/store unit; requester 1 is the loader/debug DMA port. It converts byte addresses to word addresses and rejects out-of-range accesses. It returns registered responses and can zero-fill the memory after reset.

---
 rtl/data_memory_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter between the load/store unit (port 0) and the loader/debug DMA (port 1)
// for a single-port byte-enabled data memory, with registered responses and optional zero-fill.
module data_memory_arbiter #(
  parameter int DATA_BITS      = 12,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_wren,
  input  logic [63:0]          req_addr,
  input  logic [7:0]           req_byteena,
  input  logic [63:0]          req_data,
  output logic [1:0]           rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [DATA_BITS-3:0] mem_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);

  localparam int AW = DATA_BITS - 2;

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] count;
  logic          ptr;
  logic          sel;
  logic          fire;
  logic          in_range;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_data;
  logic [3:0]    sel_byteena;
  logic          sel_wren;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    sel = ptr;
    if (req_valid == 2'b01)      sel = 1'b0;
    else if (req_valid == 2'b10) sel = 1'b1;
  end

  assign sel_addr    = sel ? req_addr[63:32]   : req_addr[31:0];
  assign sel_data    = sel ? req_data[63:32]   : req_data[31:0];
  assign sel_byteena = sel ? req_byteena[7:4]  : req_byteena[3:0];
  assign sel_wren    = sel ? req_wren[1]       : req_wren[0];
  assign in_range    = (sel_addr >> DATA_BITS) == 32'd0;
  assign busy        = (state == CLEAR);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    req_ready   = 2'b00;
    fire        = 1'b0;
    mem_address = '0;
    mem_byteena = 4'h0;
    mem_data    = 32'h0;
    mem_wren    = 1'b0;
    case (state)
      CLEAR: begin
        mem_wren    = 1'b1;
        mem_byteena = 4'hF;
        mem_address = count;
        if (count == '1) state_next = SERVE;
      end
      SERVE: begin
        if (|req_valid) begin
          fire      = 1'b1;
          req_ready = sel ? 2'b10 : 2'b01;
          if (in_range) begin
            mem_address = sel_addr[DATA_BITS-1:2];
            mem_byteena = sel_byteena;
            mem_data    = sel_data;
            mem_wren    = sel_wren;
          end
        end
      end
      default: state_next = SERVE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? CLEAR : SERVE;
      count     <= '0;
      ptr       <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_data  <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      state     <= state_next;
      if (state == CLEAR) count <= count + 1'b1;
      if (fire) ptr <= ~sel;
      rsp_valid <= req_ready;
      rsp_error <= fire & ~in_range;
      rsp_data  <= (fire && in_range && !sel_wren) ? mem_q : 32'h0;
    end
  end

endmodule
